// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: assembles a feature byte stream onto the tree's parallel bus and returns the sampled class
module dtree_feature_loader #(
  parameter int N_FEAT = 18,
  parameter int FEAT_W = 8,
  parameter int CLASS_W = 2,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FEAT_W-1:0]        in_data,
  input  logic                     in_last,
  output logic [N_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]       tree_class,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CLASS_W-1:0]       res_class,
  output logic                     res_err,
  output logic [15:0]              frame_cnt
);
  localparam int IW = $clog2(N_FEAT);
  localparam int CW = EVAL_CYCLES > 1 ? $clog2(EVAL_CYCLES) : 1;
  typedef enum logic [1:0] {LOAD, EVAL, OUT} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  assign in_ready = state == LOAD;
  assign res_valid = state == OUT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOAD;
      idx <= '0;
      cnt <= '0;
      feat_bus <= '0;
      res_class <= '0;
      res_err <= 1'b0;
      frame_cnt <= '0;
    end else
      case (state)
        LOAD: if (in_valid) begin
          feat_bus[FEAT_W*idx +: FEAT_W] <= in_data;
          if (idx == IW'(N_FEAT-1)) begin
            state <= EVAL;
            cnt <= CW'(EVAL_CYCLES-1);
            res_err <= ~in_last;
          end else if (in_last) begin
            state <= OUT;
            res_err <= 1'b1;
            res_class <= '0;
          end else
            idx <= idx + 1'b1;
        end
        EVAL: if (cnt == '0) begin
          state <= OUT;
          res_class <= tree_class;
        end else
          cnt <= cnt - 1'b1;
        OUT: if (res_ready) begin
          state <= LOAD;
          idx <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end
        default: state <= LOAD;
      endcase
endmodule
